// File: rtl/pc_sequencer_pkg.sv
// Shared widths, state encodings and helpers for the program-counter stage.
// Imported by the interface, the return-address stack and the sequencer top.
package pc_sequencer_pkg;

  localparam int WORD_SIZE = 16;
  localparam int BYTE_SIZE = 8;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [BYTE_SIZE-1:0] offset_t;

  localparam word_t DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Relative branch offsets are signed bytes widened to a full address word.
  function automatic word_t sext_offset(input offset_t off);
    return {{(WORD_SIZE - BYTE_SIZE){off[BYTE_SIZE-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode/execute and the PC sequencer.
// master = the stage issuing control, slave = the sequencer.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic    stall;
  logic    halt;
  logic    resume;
  logic    branch_en;
  logic    branch_rel;
  word_t   branch_target;
  offset_t branch_offset;
  logic    call;
  logic    ret;

  word_t   pointer;
  logic    running;
  logic    ras_overflow;
  logic    ras_underflow;

  modport master (
    output stall, halt, resume, branch_en, branch_rel,
           branch_target, branch_offset, call, ret,
    input  pointer, running, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, halt, resume, branch_en, branch_rel,
           branch_target, branch_offset, call, ret,
    output pointer, running, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// and the count saturates at DEPTH so pops never return overwritten slots.
module ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t dout,
  output logic  empty,
  output logic  full,
  output logic  overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  // Pop takes precedence so a simultaneous request never corrupts the top.
  assign do_pop   = pop && !empty;
  assign do_push  = push && !do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign dout     = mem[top];
  assign overflow = do_push && full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
    end else if (do_pop) begin
      top   <= top - PTR_W'(1);
      count <= count - CNT_W'(1);
    end else if (do_push) begin
      top <= top + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; count==0 already marks every entry
  // invalid, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[top + PTR_W'(1)] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction fetch: RUN/HALTED FSM,
// next-pointer priority mux, return-address stack and sticky RAS flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int    RAS_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  state_t state, state_next;
  word_t  ptr_q, ptr_d;
  word_t  branch_dest;
  word_t  stack_dout;
  logic   push, pop;
  logic   stack_empty, stack_full, stack_ovf;
  logic   ovf_q, unf_q, unf_set;

  ret_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (ptr_q + word_t'(1)),
    .dout     (stack_dout),
    .empty    (stack_empty),
    .full     (stack_full),
    .overflow (stack_ovf)
  );

  // Calls and branches share one destination rule.
  assign branch_dest = bus.branch_rel ? ptr_q + sext_offset(bus.branch_offset)
                                      : bus.branch_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (bus.halt)                 state_next = ST_HALTED;
      ST_HALTED: if (bus.resume && !bus.halt)  state_next = ST_RUN;
      default:                                 state_next = ST_RUN;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    push    = 1'b0;
    pop     = 1'b0;
    unf_set = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.halt || bus.stall) begin
          ptr_d = ptr_q;
        end else if (bus.ret) begin
          if (!stack_empty) begin
            ptr_d = stack_dout;
            pop   = 1'b1;
          end else begin
            ptr_d   = ptr_q + word_t'(1);
            unf_set = 1'b1;
          end
        end else if (bus.call) begin
          ptr_d = branch_dest;
          push  = 1'b1;
        end else if (bus.branch_en) begin
          ptr_d = branch_dest;
        end else begin
          ptr_d = ptr_q + word_t'(1);
        end
      end
      ST_HALTED: begin
        if (bus.resume && !bus.halt) ptr_d = ptr_q + word_t'(1);
      end
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (stack_ovf) ovf_q <= 1'b1;
      if (unf_set)   unf_q <= 1'b1;
    end
  end

  always_comb begin
    bus.running = (state == ST_RUN);
  end

  assign bus.pointer       = ptr_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage directly upstream of instruction fetch. Produces the registered `pointer` word consumed by `instr_fetch` every cycle. Control inputs come from the decode/execute stages and select the next address: sequential increment, absolute or relative branch, call/return via a small return-address stack, stall, or halt.

Parameters:
WORD_SIZE, 16, address/data word width (from parameters.v)
BYTE_SIZE, 8, relative branch offset width (from parameters.v)
RESET_VECTOR, 16'h0000, pointer value after reset
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
stall  input  1  hold pointer; ignore control inputs this cycle
halt  input  1  enter HALTED state
resume  input  1  leave HALTED state
branch_en  input  1  take branch this cycle
branch_rel  input  1  1 = pointer + sign-extended offset; 0 = absolute target
branch_target  input  WORD_SIZE  absolute destination
branch_offset  input  BYTE_SIZE  signed two's-complement relative offset
call  input  1  branch (same target selection) and push pointer+1
ret  input  1  pop the return-address stack into pointer
pointer  output  WORD_SIZE  current fetch address, registered
running  output  1  1 when state == RUN
ras_overflow  output  1  sticky; a push discarded the oldest entry
ras_underflow  output  1  sticky; ret issued with stack empty

Behaviour:
- Reset, asynchronous: pointer=RESET_VECTOR; state=RUN; stack empty (count=0); ras_overflow=0; ras_underflow=0. Reset asserted mid-operation aborts everything immediately, and the stack contents become don't-care.
- Output timing: all outputs come from registers or decode of a register; no combinational input-to-output path. Any control input takes effect on pointer one clock later.
- States: RUN, HALTED. Encodings are in parameters.v.
- RUN, next-pointer priority, highest first:
  1. halt: go to HALTED; pointer holds.
  2. stall: pointer holds; branch/call/ret are dropped and not remembered.
  3. ret: if count>0, pointer<=top entry and pop. If count==0, pointer<=pointer+1 and ras_underflow<=1.
  4. call: pointer<=target, using the same rel/abs rule as a branch; push pointer+1 (wraps). branch_en is ignored when call is asserted.
  5. branch_en: pointer<=branch_target if branch_rel=0. Otherwise pointer<=pointer+{sign-extended branch_offset}.
  6. otherwise: pointer<=pointer+1.
- call and ret in the same cycle: ret wins, and no push occurs.
- All address arithmetic is modulo 2^WORD_SIZE. FFFF+1=0000; 0002+(-4)=FFFE.
- Stack: circular LIFO.
  - Push when count==RAS_DEPTH: the oldest entry is overwritten, count stays RAS_DEPTH, and ras_overflow<=1.
  - Pop returns the most recent push.
- HALTED:
  - pointer holds; stall, branch, call and ret are ignored.
  - resume=1 and halt=0: go to RUN and pointer<=pointer+1 in the same edge.
  - halt and resume together: stay HALTED.
- Sticky flags clear only on reset.

Decomposition:
- parameters.v (shared include) holds: WORD_SIZE, BYTE_SIZE, state encodings ST_RUN/ST_HALTED, and the default RESET_VECTOR.
- One sub-module, ret_stack. Ports: clk, reset, push, pop, din, dout (top entry), empty, full, overflow pulse. It contains a circular buffer with a pointer and a saturating count.
- pc_sequencer contains the FSM, the next-pointer mux and the sticky flags.

Test Plan:
- Reset release, no controls for 5 cycles -> pointer 0000,0001,0002,0003,0004; running=1; both flags 0.
- At pointer 0010: branch_en, abs, target 0100 -> next 0100. Then branch_rel with offset 8'hFC -> 00FC.
- At pointer 0020: call abs 0200, then 3 idle cycles, then ret -> sequence 0200,0201,0202,0203, then 0021.
- 5 nested calls (RAS_DEPTH=4), then 5 rets -> ras_overflow=1 after the 5th call. First 4 rets return addresses in reverse order. The 5th ret gives pointer+1 with ras_underflow=1.
- Stall together with branch_en for 2 cycles at pointer 0030 -> pointer stays 0030; branch is dropped; increments to 0031 after stall drops.
- Halt at 0040; resume and halt together for 1 cycle; then resume alone -> pointer 0040 and running=0 until the resume-alone cycle, then 0041 and running=1.
- Asynchronous reset pulse between clock edges while pointer=0050 with a non-empty stack -> pointer=0000 immediately; a subsequent ret sets ras_underflow.
